// File: rtl/vend_seq_if.sv
// vend_seq_if: coin acceptor, vending FSM, dispenser and hopper signals of the vend sequencer
interface vend_seq_if;
    logic       coin_valid_i;
    logic [1:0] coin_type_i;
    logic       coin_ready_o;
    logic       reject_o;
    logic       nickle_o;
    logic       dime_o;
    logic       quarter_o;
    logic       soda_i;
    logic [2:0] change_i;
    logic       dispense_o;
    logic       dispense_done_i;
    logic       hopper_o;
    logic       hopper_ack_i;
    logic       busy_o;
    logic       err_o;
    modport slave (
        input  coin_valid_i, coin_type_i, soda_i, change_i, dispense_done_i, hopper_ack_i,
        output coin_ready_o, reject_o, nickle_o, dime_o, quarter_o, dispense_o, hopper_o,
               busy_o, err_o
    );
    modport master (
        output coin_valid_i, coin_type_i, soda_i, change_i, dispense_done_i, hopper_ack_i,
        input  coin_ready_o, reject_o, nickle_o, dime_o, quarter_o, dispense_o, hopper_o,
               busy_o, err_o
    );
endinterface

// File: rtl/vend_seq.sv
// vend_seq: coin-to-pulse sequencer driving the soda FSM, dispenser motor and change hopper
module vend_seq #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input logic       clk_i,
    input logic       rst_i,
    vend_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, COIN, DISP, PAY, PGAP, ERR} state_t;
    state_t        state, state_n;
    logic [1:0]    type_q;
    logic [2:0]    cnt;
    logic [TW-1:0] tmr;
    logic          rej_q;
    logic          accept;
    logic          expired;
    assign accept  = bus.coin_valid_i && bus.coin_ready_o;
    assign expired = tmr == TW'(TIMEOUT - 1);
    // The wait counter restarts on every state change, so it only ever counts one wait.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            type_q <= '0;
            cnt    <= '0;
            tmr    <= '0;
            rej_q  <= 1'b0;
        end else begin
            state  <= state_n;
            rej_q  <= accept && bus.coin_type_i == 2'b11;
            type_q <= accept ? bus.coin_type_i : type_q;
            cnt    <= state == COIN ? bus.change_i :
                      (state == PAY && bus.hopper_ack_i) ? cnt - 3'd1 : cnt;
            tmr    <= state_n != state ? '0 : tmr + TW'(1);
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (accept && bus.coin_type_i != 2'b11) ? COIN : IDLE;
            COIN:    state_n = bus.soda_i ? DISP : (bus.change_i != 3'd0 ? PAY : IDLE);
            DISP:    state_n = bus.dispense_done_i ? (cnt != 3'd0 ? PAY : IDLE) :
                               (expired ? ERR : DISP);
            PAY:     state_n = bus.hopper_ack_i ? PGAP : (expired ? ERR : PAY);
            PGAP:    state_n = cnt != 3'd0 ? PAY : IDLE;
            default: state_n = state;
        endcase
    end
    assign bus.err_o        = state == ERR;
    assign bus.coin_ready_o = state == IDLE && !bus.err_o;
    assign bus.busy_o       = state != IDLE;
    assign bus.reject_o     = rej_q;
    assign bus.nickle_o     = state == COIN && type_q == 2'b00;
    assign bus.dime_o       = state == COIN && type_q == 2'b01;
    assign bus.quarter_o    = state == COIN && type_q == 2'b10;
    assign bus.dispense_o   = state == DISP;
    assign bus.hopper_o     = state == PAY;
endmodule

// File: doc/vend_seq.md
Name: vend_seq

Overview:
- Front-end sequencer for the soda vending FSM (one-hot coin inputs `nickle`/`dime`/`quarter`; outputs `soda` and a 3-bit change count in nickels).
- Accepts coins from a coin acceptor over a valid/ready handshake and converts each coin into a single-cycle pulse to the FSM.
- Captures the FSM's vend/change result, then runs the soda dispenser motor and the nickel change hopper through their handshakes.
- Blocks new coins while a vend or payout is in progress.

Parameters:
- TIMEOUT, 255, max cycles to wait for `dispense_done_i` or `hopper_ack_i` before error.
- TW, 8, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- coin_valid_i  input  1  coin acceptor has a coin.
- coin_type_i  input  2  00 nickel, 01 dime, 10 quarter, 11 invalid.
- coin_ready_o  output  1  sequencer accepts a coin this cycle.
- reject_o  output  1  one-cycle pulse: accepted coin had type 11.
- nickle_o  output  1  one-cycle pulse to FSM `nickle` input.
- dime_o  output  1  one-cycle pulse to FSM `dime` input.
- quarter_o  output  1  one-cycle pulse to FSM `quarter` input.
- soda_i  input  1  FSM soda output.
- change_i  input  3  FSM change output, in nickels, 0..4.
- dispense_o  output  1  dispenser motor enable.
- dispense_done_i  input  1  dispenser finished.
- hopper_o  output  1  request one nickel from the hopper.
- hopper_ack_i  input  1  hopper paid one nickel.
- busy_o  output  1  state is not IDLE.
- err_o  output  1  sticky timeout error.

Behaviour:
- Reset: state IDLE, all outputs 0 except `coin_ready_o` = 1, counters 0, `err_o` 0. Reset in any state (mid-dispense, mid-payout) aborts immediately; `dispense_o` and `hopper_o` are low the cycle after reset is sampled. The FSM is not reset by this block.
- `coin_ready_o` = (state == IDLE) && !`err_o`. A coin is accepted on an edge where `coin_valid_i` && `coin_ready_o`. Unaccepted coins are held by the acceptor; no buffering here.
- States: IDLE, COIN, DISP, PAY, PGAP, ERR.
- IDLE, accept with type 00/01/10: latch the type and go to COIN.
- IDLE, accept with type 11: stay in IDLE and pulse `reject_o` for one cycle (the cycle after accept). No FSM pulse.
- COIN (exactly 1 cycle):
  - Drive exactly one of `nickle_o`/`dime_o`/`quarter_o` high.
  - In the same cycle, sample `soda_i` into `soda_q` and `change_i` into `cnt` (FSM outputs are combinational on its inputs).
  - Next state: `soda_q` ? DISP : (`cnt` != 0 ? PAY : IDLE).
- DISP: `dispense_o` = 1. On `dispense_done_i`, go to PAY if `cnt` != 0, else IDLE. `dispense_o` is low in the next cycle.
- PAY: `hopper_o` = 1. On `hopper_ack_i`, decrement `cnt` and go to PGAP.
- PGAP (1 cycle, `hopper_o` = 0): go to PAY if `cnt` != 0, else IDLE. Each nickel is a separate request; there are never two acks per request.
- Timeout:
  - Counter clears on entry to DISP or PAY and increments each cycle waiting.
  - If it reaches TIMEOUT without done/ack: go to ERR, set `err_o`, drop `dispense_o`/`hopper_o`.
  - ERR is left only by `rst_i`.
- Done/ack on the same cycle the counter reaches TIMEOUT: done/ack wins, no error.
- Spurious `dispense_done_i`/`hopper_ack_i` outside DISP/PAY: ignored.
- `cnt` values above 4 are paid out as given; there is no saturation.
- `busy_o` = (state != IDLE), registered state decode.
- Latency from accept to FSM pulse is 1 cycle. Minimum coin-to-coin spacing with no vend is 2 cycles (IDLE, COIN, IDLE).

Test Plan:
- Reset, then nickel (type 00) with FSM returning `soda_i`=0, `change_i`=0 -> `nickle_o` pulse exactly 1 cycle after accept; `busy_o` high 1 cycle; `coin_ready_o` back to 1 two cycles after accept.
- Quarter from FSM state 15c, `soda_i`=1, `change_i`=4 -> `dispense_o` high until `dispense_done_i`; then 4 `hopper_o` requests, each separated by one low PGAP cycle; `cnt` reaches 0; return to IDLE.
- Type 11 coin -> `coin_ready_o`=1 at accept, `reject_o` one-cycle pulse, no `nickle_o`/`dime_o`/`quarter_o`, state stays IDLE.
- `coin_valid_i` held high during DISP -> `coin_ready_o`=0 and no FSM pulse until IDLE; the coin is accepted on the first IDLE cycle.
- TIMEOUT=10, `hopper_ack_i` never asserted -> after 10 waiting cycles: `err_o`=1, `hopper_o`=0, `coin_ready_o`=0, stuck until `rst_i`. Separately, ack on exactly cycle 10 -> no error.
- `rst_i` asserted during 2nd of 3 nickel payouts -> next cycle `hopper_o`=0, `busy_o`=0, `coin_ready_o`=1, `err_o`=0.
